// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input vector of an N_IN-input combinational
// block, lets it settle, compares each of N_CH response channels against the
// EXPECT truth table and accumulates a mismatch count and per-channel flags.
// Optional build macro TRUTH_TABLE_SWEEPER_GRAY_SWEEP_EN sweeps vectors in Gray
// order instead of ascending binary; indexing, latency and counts are unchanged.
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int N_CH   = 2,
    parameter int SETTLE = 1,
    parameter logic [N_CH*(2**N_IN)-1:0] EXPECT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   dut_in,
    input  logic [N_CH-1:0]   dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN+3:0]   err_cnt,
    output logic [N_CH-1:0]   ch_fail
);

    localparam int              NVEC        = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX    = {N_IN{1'b1}};
    localparam logic [3:0]      SETTLE_INIT = 4'(SETTLE);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        CHECK,
        FIN
    } state_t;

    state_t            state;
    logic [N_IN-1:0]   idx;
    logic [3:0]        settle_cnt;
    logic [N_IN-1:0]   vec;
    logic [N_CH-1:0]   mismatch;
    logic [N_IN+3:0]   mis_count;

    // Map the sweep position to the vector actually applied (binary or Gray order)
    always_comb begin
`ifdef TRUTH_TABLE_SWEEPER_GRAY_SWEEP_EN
        vec = idx ^ (idx >> 1);
`else
        vec = idx;
`endif
    end

    // Per-channel mismatch mask for the vector currently on dut_in, and its popcount
    always_comb begin
        mismatch  = '0;
        mis_count = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            mismatch[ch] = dut_out[ch] ^ EXPECT[ch*NVEC + int'(vec)];
            mis_count    = mis_count + (N_IN+4)'(mismatch[ch]);
        end
    end

    // Sweep controller; abort from any active state drops straight back to IDLE keeping the counts
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            ch_fail    <= '0;
            idx        <= '0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                state  <= IDLE;
                busy   <= 1'b0;
                dut_in <= '0;
                pass   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state   <= APPLY;
                            busy    <= 1'b1;
                            idx     <= '0;
                            err_cnt <= '0;
                            ch_fail <= '0;
                            pass    <= 1'b0;
                        end
                    end
                    APPLY: begin
                        dut_in     <= vec;
                        settle_cnt <= SETTLE_INIT;
                        state      <= WAIT;
                    end
                    WAIT: begin
                        settle_cnt <= settle_cnt - 4'd1;
                        if (settle_cnt == 4'd1) begin
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        err_cnt <= err_cnt + mis_count;
                        ch_fail <= ch_fail | mismatch;
                        if (idx == LAST_IDX) begin
                            state <= FIN;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= APPLY;
                        end
                    end
                    FIN: begin
                        done   <= 1'b1;
                        pass   <= (err_cnt == '0);
                        dut_in <= '0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter N_IN, default 3: DUT input count, legal 1..8.
REQ-002 SHALL have parameter N_CH, default 2: DUT output channel count, legal 1..8.
REQ-003 SHALL have parameter SETTLE, default 1: wait cycles between applying a vector and sampling, legal 1..15.
REQ-004 SHALL have parameter EXPECT, width N_CH*2^N_IN, default 0: bit [ch*2^N_IN + v] is the expected output of channel ch for input vector v.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: request to begin a sweep.
REQ-008 SHALL have port abort, input, 1: cancel the sweep in progress.
REQ-009 SHALL have port dut_in, output, N_IN: registered stimulus vector for the DUTs.
REQ-010 SHALL have port dut_out, input, N_CH: DUT responses, one bit per channel.
REQ-011 SHALL have port busy, output, 1: high while a sweep is in progress.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when a sweep completes.
REQ-013 SHALL have port pass, output, 1: high when the last completed sweep had zero mismatches.
REQ-014 SHALL have port err_cnt, output, N_IN+4: total mismatched bits in the current or last sweep.
REQ-015 SHALL have port ch_fail, output, N_CH: sticky per-channel mismatch flags.

Function
REQ-016 SHALL implement FSM states IDLE, APPLY, WAIT, CHECK and FIN.
REQ-017 IDLE SHALL move to APPLY on start=1 with abort=0, and in that same edge SHALL clear idx, err_cnt, ch_fail and pass.
REQ-018 APPLY SHALL load dut_in with vec(idx), load the settle counter with SETTLE, and move to WAIT.
REQ-019 WAIT SHALL decrement the settle counter and move to CHECK when it reaches 0, so the dwell is SETTLE cycles.
REQ-020 CHECK SHALL compare dut_out[ch] against EXPECT[ch*2^N_IN + vec(idx)] for every channel.
REQ-021 CHECK SHALL add the popcount of the mismatch mask to err_cnt and OR the mask into ch_fail.
REQ-022 From CHECK, idx = 2^N_IN-1 SHALL move to FIN; any other idx SHALL increment idx and move to APPLY.
REQ-023 FIN SHALL assert done for exactly one cycle, set pass = (err_cnt == 0), drive dut_in to 0, and return to IDLE.
REQ-024 Each vector SHALL occupy SETTLE+2 cycles; done SHALL assert 2^N_IN*(SETTLE+2)+1 cycles after the edge that accepts start.
REQ-025 busy SHALL be high in every state except IDLE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 abort in any non-IDLE state SHALL force IDLE on the next edge: busy=0, dut_in=0, pass=0, no done; err_cnt and ch_fail hold.
REQ-028 When start and abort are both high in IDLE, abort SHALL win and no sweep starts.
REQ-029 err_cnt SHALL not overflow; its maximum is N_CH*2^N_IN < 2^(N_IN+4).
REQ-030 pass, err_cnt and ch_fail SHALL hold after done until the next accepted start.

Reset
REQ-031 rst=1 SHALL, at the next edge, force state=IDLE and dut_in, busy, done, pass, err_cnt, ch_fail and idx all to 0.
REQ-032 rst SHALL take priority over start and abort, including mid-sweep.

Configuration
REQ-033 With macro TRUTH_TABLE_SWEEPER_GRAY_SWEEP_EN undefined, vec(idx) SHALL equal idx, giving ascending binary order 0..2^N_IN-1.
REQ-034 With TRUTH_TABLE_SWEEPER_GRAY_SWEEP_EN defined, vec(idx) SHALL equal idx ^ (idx>>1) (Gray order); EXPECT indexing, latency and counts SHALL be unchanged.

Verification
REQ-035 N_IN=3, N_CH=1, SETTLE=1, EXPECT=8'b11101000, majority DUT, start -> done 25 cycles after start; pass=1; err_cnt=0; ch_fail=0.
REQ-036 Same configuration with the DUT output stuck at 0 -> err_cnt=4, ch_fail=1'b1, pass=0.
REQ-037 N_IN=4, N_CH=2, ch0 correct, ch1 inverted -> err_cnt=16, ch_fail=2'b10, pass=0.
REQ-038 abort asserted 10 cycles after start -> busy=0 and dut_in=0 on the next cycle, no done pulse, pass=0; a second start pulse while busy is ignored (done count stays 1 per sweep).
REQ-039 rst pulsed mid-sweep -> all outputs 0 at the next edge; a following start completes a normal sweep.
REQ-040 With the Gray macro defined and N_IN=3 -> dut_in sequence 0,1,3,2,6,7,5,4; the REQ-035 result is unchanged.
